// File: rtl/complex_stream_mult.sv
// Streaming complex multiplier: input FIFO -> lane-neighbour multiply pipeline -> output FIFO.
// Pops are gated by a credit rule so every line in flight already owns a slot in the output FIFO.

module complex_stream_fifo #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module complex_stream_mult #(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES           = 8,
  parameter int FRAC_BITS       = 0,
  parameter int MULT_LATENCY    = 3,
  parameter int BUFF_DEPTH_BITS = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [31:0]                       ctx_length,
  input  logic [2*DATA_WIDTH*LANES-1:0]     input_fifo_din,
  input  logic                              input_fifo_we,
  output logic                              input_fifo_full,
  output logic                              input_fifo_almost_full,
  output logic [BUFF_DEPTH_BITS:0]          input_fifo_count,
  output logic [2*DATA_WIDTH*LANES-1:0]     output_fifo_dout,
  input  logic                              output_fifo_re,
  output logic                              output_fifo_empty,
  output logic                              output_fifo_almost_empty,
  output logic                              busy,
  output logic                              done
);
  localparam int W     = 2*DATA_WIDTH*LANES;
  localparam int CW    = 2*DATA_WIDTH;
  localparam int PW    = 2*DATA_WIDTH + 1;
  localparam int AW    = BUFF_DEPTH_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [31:0]       ctx_len_q;
  logic [31:0]       issued_q;
  logic [31:0]       written_q;
  logic [AW:0]       inflight_q;
  logic [AW:0]       out_count;
  logic [AW+1:0]     credit_used;
  logic              in_empty;
  logic              out_full;
  logic              pop;
  logic              pop_q;
  logic              out_we;
  logic              start_ok;
  logic [W-1:0]      in_line;
  logic [W-1:0]      product_line;
  logic [W-1:0]      stage_data [MULT_LATENCY];
  logic [MULT_LATENCY-1:0] stage_valid;

  complex_stream_fifo #(.DW(W), .AW(AW)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (input_fifo_we),
    .din   (input_fifo_din),
    .re    (pop),
    .dout  (in_line),
    .count (input_fifo_count),
    .full  (input_fifo_full),
    .empty (in_empty)
  );

  complex_stream_fifo #(.DW(W), .AW(AW)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (out_we),
    .din   (stage_data[MULT_LATENCY-1]),
    .re    (output_fifo_re),
    .dout  (output_fifo_dout),
    .count (out_count),
    .full  (out_full),
    .empty (output_fifo_empty)
  );

  assign input_fifo_almost_full   = (int'(input_fifo_count) >= DEPTH - 4);
  assign output_fifo_almost_empty = (out_count <= (AW+1)'(2));
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign out_we   = stage_valid[MULT_LATENCY-1];
  assign credit_used = (AW+2)'(out_count) + (AW+2)'(inflight_q);

  // One complex lane: a times b (mode 0), a times conj(b) (mode 1), or a unchanged.
  function automatic logic [CW-1:0] lane_op(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic [1:0]    op);
    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] re_full, im_full, re_sh, im_sh;
    ar = {{(PW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a[DATA_WIDTH-1:0]};
    ai = {{(PW-DATA_WIDTH){a[CW-1]}},         a[CW-1:DATA_WIDTH]};
    br = {{(PW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b[DATA_WIDTH-1:0]};
    bi = {{(PW-DATA_WIDTH){b[CW-1]}},         b[CW-1:DATA_WIDTH]};
    if (op[1]) return a;
    // Conjugate is folded into the sign pattern so a most-negative imag never needs negating.
    if (op[0]) begin
      re_full = ar*br + ai*bi;
      im_full = ai*br - ar*bi;
    end else begin
      re_full = ar*br - ai*bi;
      im_full = ar*bi + ai*br;
    end
    re_sh = re_full >>> FRAC_BITS;
    im_sh = im_full >>> FRAC_BITS;
    return {im_sh[DATA_WIDTH-1:0], re_sh[DATA_WIDTH-1:0]};
  endfunction

  always_comb begin
    product_line = '0;
    for (int k = 0; k < LANES; k++) begin
      product_line[k*CW +: CW] = lane_op(in_line[k*CW +: CW],
                                         in_line[((k+1)%LANES)*CW +: CW], mode_q);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state_q;
    pop     = (state_q == RUN) && !in_empty && (issued_q < ctx_len_q) &&
              (credit_used < (AW+2)'(DEPTH));
    case (state_q)
      IDLE, DONE: if (start) state_d = (ctx_length == 32'd0) ? DONE : RUN;
      RUN:        if (pop && (issued_q + 32'd1 == ctx_len_q)) state_d = DRAIN;
      DRAIN:      if (out_we && (written_q + 32'd1 == ctx_len_q)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      ctx_len_q   <= '0;
      issued_q    <= '0;
      written_q   <= '0;
      inflight_q  <= '0;
      pop_q       <= 1'b0;
      stage_valid <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q    <= mode;
        ctx_len_q <= ctx_length;
        issued_q  <= '0;
        written_q <= '0;
      end else begin
        if (pop)    issued_q  <= issued_q + 32'd1;
        if (out_we) written_q <= written_q + 32'd1;
      end
      case ({pop, out_we})
        2'b10:   inflight_q <= inflight_q + (AW+1)'(1);
        2'b01:   inflight_q <= inflight_q - (AW+1)'(1);
        default: ;
      endcase
      pop_q          <= pop;
      stage_valid[0] <= pop_q;
      for (int i = 1; i < MULT_LATENCY; i++) stage_valid[i] <= stage_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_data[0] <= product_line;
    for (int i = 1; i < MULT_LATENCY; i++) stage_data[i] <= stage_data[i-1];
  end
endmodule

// File: tb/tb_complex_stream_mult.sv
// Directed bench for complex_stream_mult: modes, latency, credit stall, partial jobs, mid-job reset.

module tb_complex_stream_mult;
  localparam int DW    = 32;
  localparam int LANES = 8;
  localparam int ML    = 3;
  localparam int BDB   = 3;
  localparam int W     = 2*DW*LANES;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [31:0]    ctx_length;
  logic [W-1:0]   input_fifo_din;
  logic           input_fifo_we;
  logic           input_fifo_full;
  logic           input_fifo_almost_full;
  logic [BDB:0]   input_fifo_count;
  logic [W-1:0]   output_fifo_dout;
  logic           output_fifo_re;
  logic           output_fifo_empty;
  logic           output_fifo_almost_empty;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  complex_stream_mult #(
    .DATA_WIDTH(DW), .LANES(LANES), .FRAC_BITS(0), .MULT_LATENCY(ML), .BUFF_DEPTH_BITS(BDB)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .mode                     (mode),
    .ctx_length               (ctx_length),
    .input_fifo_din           (input_fifo_din),
    .input_fifo_we            (input_fifo_we),
    .input_fifo_full          (input_fifo_full),
    .input_fifo_almost_full   (input_fifo_almost_full),
    .input_fifo_count         (input_fifo_count),
    .output_fifo_dout         (output_fifo_dout),
    .output_fifo_re           (output_fifo_re),
    .output_fifo_empty        (output_fifo_empty),
    .output_fifo_almost_empty (output_fifo_almost_empty),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int k, input int re_v, input int im_v);
    logic [W-1:0] l = '0;
    l[2*k*DW +: DW]      = re_v;
    l[2*k*DW + DW +: DW] = im_v;
    return l;
  endfunction

  // Stream line i and its mode-0 result: (i + j) * (2 + 0j) = (2i, 2) in lane 0, zero elsewhere.
  function automatic logic [W-1:0] seq_in(input int i);
    return lane(0, i, 1) | lane(1, 2, 0);
  endfunction

  function automatic logic [W-1:0] seq_out(input int i);
    return lane(0, 2*i, 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] l);
    input_fifo_din = l;
    input_fifo_we  = 1'b1;
    step();
    input_fifo_we  = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] m, input int len);
    mode       = m;
    ctx_length = len;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic read_line(input string tag, input logic [W-1:0] exp);
    int n = 0;
    while (output_fifo_empty && n < 300) begin
      step();
      n++;
    end
    check({tag, "_avail"}, !output_fifo_empty, 1);
    output_fifo_re = 1'b1;
    step();
    output_fifo_re = 1'b0;
    check(tag, output_fifo_dout, exp);
  endtask

  logic [W-1:0] vin;
  logic [W-1:0] exp_mode [4];

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; ctx_length = '0;
    input_fifo_din = '0; input_fifo_we = 1'b0; output_fifo_re = 1'b0;

    vin = lane(0, 3, 4) | lane(1, 1, 2) | lane(2, 65536, 0) | lane(3, 65536, 1) | lane(7, 2, -1);
    exp_mode[0] = lane(0, -5, 10) | lane(1, 65536, 131072) | lane(2, 0, 65536)  | lane(7, 10, 5);
    exp_mode[1] = lane(0, 11, -2) | lane(1, 65536, 131072) | lane(2, 0, -65536) | lane(7, 2, -11);
    exp_mode[2] = vin;
    exp_mode[3] = vin;

    // Reset state
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", output_fifo_empty, 1);
    check("rst_aempty", output_fifo_almost_empty, 1);
    check("rst_full", input_fifo_full, 0);
    check("rst_afull", input_fifo_almost_full, 0);
    check("rst_count", input_fifo_count, 0);
    check("rst_dout", output_fifo_dout, '0);
    reset = 1'b0;
    step();

    // Zero-length job: straight to DONE, nothing popped
    push(seq_in(0));
    start_job(2'd0, 0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    repeat (6) step();
    check("len0_count", input_fifo_count, 1);
    check("len0_empty", output_fifo_empty, 1);

    // Five lines preloaded, job of three leaves two behind
    for (int i = 1; i < 5; i++) push(seq_in(i));
    check("pre5_count", input_fifo_count, 5);
    start_job(2'd0, 3);
    wait_done("part1_done");
    check("part1_left", input_fifo_count, 2);
    for (int i = 0; i < 3; i++) read_line($sformatf("part1_out%0d", i), seq_out(i));
    start_job(2'd0, 2);
    wait_done("part2_done");
    check("part2_left", input_fifo_count, 0);
    for (int i = 3; i < 5; i++) read_line($sformatf("part2_out%0d", i), seq_out(i));

    // Each mode on the same vector, with pop-to-not-empty latency
    for (int m = 0; m < 4; m++) begin
      int n;
      push(vin);
      start_job(m[1:0], 1);
      check($sformatf("m%0d_busy", m), busy, 1);
      n = 1;
      while (output_fifo_empty && n < 30) begin
        step();
        n++;
      end
      check($sformatf("m%0d_latency", m), n, ML + 3);
      check($sformatf("m%0d_done", m), done, 1);
      check($sformatf("m%0d_count", m), input_fifo_count, 0);
      read_line($sformatf("m%0d_out", m), exp_mode[m]);
      check($sformatf("m%0d_empty_after", m), output_fifo_empty, 1);
    end

    // Twenty lines with the output held: credits stall pops at eight, then drain in order
    start_job(2'd0, 20);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int n = 0;
          while (input_fifo_full && n < 1000) begin
            step();
            n++;
          end
          push(seq_in(100 + i));
        end
      end
      begin
        repeat (60) step();
        check("stall_busy", busy, 1);
        check("stall_done", done, 0);
        check("stall_in_count", input_fifo_count, 8);
        check("stall_in_full", input_fifo_full, 1);
        check("stall_in_afull", input_fifo_almost_full, 1);
        check("stall_out_aempty", output_fifo_almost_empty, 0);
        for (int i = 0; i < 20; i++) read_line($sformatf("s20_out%0d", i), seq_out(100 + i));
        wait_done("s20_done");
        check("s20_empty", output_fifo_empty, 1);
        check("s20_in_count", input_fifo_count, 0);
      end
    join

    // Reset with four lines in flight discards everything
    for (int i = 0; i < 6; i++) push(seq_in(200 + i));
    start_job(2'd2, 6);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_empty", output_fifo_empty, 1);
    check("mrst_count", input_fifo_count, 0);
    check("mrst_dout", output_fifo_dout, '0);
    begin
      int stale = 0;
      for (int i = 0; i < 10; i++) begin
        if (!output_fifo_empty) stale++;
        step();
      end
      check("mrst_stale_writes", stale, 0);
    end
    check("mrst_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/complex_stream_mult.md
COMPLEX_STREAM_MULT -- requirements
Module: complex_stream_mult

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one real or imaginary component (two's-complement fixed point).
REQ-002 Parameter LANES, 8, complex words per line; line width W = 2*DATA_WIDTH*LANES.
REQ-003 Parameter FRAC_BITS, 0, fractional bits of the fixed-point format.
REQ-004 Parameter MULT_LATENCY, 3, pipeline register stages in the multiply datapath (>=1).
REQ-005 Parameter BUFF_DEPTH_BITS, 3, log2 depth D of the input and output FIFOs.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  single-cycle pulse that begins a job; ignored unless state is IDLE or DONE.
REQ-009 mode  input  2  operation, latched on accepted start: 0 neighbour product, 1 neighbour conjugate product, 2/3 passthrough.
REQ-010 ctx_length  input  32  lines in the job, latched on accepted start.
REQ-011 input_fifo_din  input  W  line; lane k real at [2kD'+D'-1:2kD'], imag at [2kD'+2D'-1:2kD'+D'] with D'=DATA_WIDTH.
REQ-012 input_fifo_we  input  1  write strobe; dropped when input_fifo_full.
REQ-013 input_fifo_full / input_fifo_almost_full  output  1 each  count==D / count>=D-4.
REQ-014 input_fifo_count  output  BUFF_DEPTH_BITS+1  input FIFO occupancy.
REQ-015 output_fifo_dout  output  W  result line, same lane packing.
REQ-016 output_fifo_re  input  1  read strobe; ignored when output_fifo_empty.
REQ-017 output_fifo_empty / output_fifo_almost_empty  output  1 each  count==0 / count<=2.
REQ-018 busy  output  1  high in RUN and DRAIN.
REQ-019 done  output  1  high in DONE.

Function
REQ-020 States IDLE, RUN, DRAIN, DONE; accepted start -> RUN, or -> DONE directly if ctx_length==0.
REQ-021 RUN: pop input FIFO when not empty, issued<ctx_length, and out_count+inflight<D (credit rule); output FIFO never overflows.
REQ-022 RUN -> DRAIN on the cycle issued reaches ctx_length; DRAIN -> DONE the cycle written reaches ctx_length.
REQ-023 DONE holds until accepted start; a start in DONE clears issued/written counters and relaunches.
REQ-024 Lines in input FIFO beyond ctx_length remain unpopped for the next job.
REQ-025 Mode 0: out[k] = in[k] * in[(k+1) mod LANES]; mode 1: out[k] = in[k] * conj(in[(k+1) mod LANES]); mode 2/3: out[k] = in[k].
REQ-026 Products computed at full 2*DATA_WIDTH+1 precision, arithmetic-shifted right by FRAC_BITS, truncated (wrap) to DATA_WIDTH; no saturation.
REQ-027 Pop in cycle t -> output FIFO write in cycle t+1+MULT_LATENCY; output_fifo_empty low from t+2+MULT_LATENCY.
REQ-028 One line per cycle sustained throughput when input non-empty and credits available.
REQ-029 Both FIFOs: read data appears on dout the cycle after an accepted read (registered read); simultaneous read and write at full/empty keeps count consistent.
REQ-030 inflight counter increments on pop, decrements on output write; net zero when both occur together.

Reset
REQ-031 reset: state IDLE, both FIFOs empty, counters/inflight 0, pipeline valid bits 0, busy 0, done 0, empty 1, full 0, counts 0, dout 0.
REQ-032 reset mid-job discards in-flight and buffered lines; no output write occurs in the cycle after reset deasserts.

Verification
REQ-033 FRAC_BITS=0, mode 0, lane0=(3,4), lane1=(1,2), ctx_length=1 -> out lane0=(-5,10); done rises after one write.
REQ-034 Same input, mode 1 -> out lane0=(11,-2); mode 2 -> out lane0=(3,4).
REQ-035 ctx_length=20, D=8, output_fifo_re held low -> exactly 8 lines written, pops stall, no overflow; releasing re completes all 20, done=1.
REQ-036 ctx_length=0 with start -> DONE next cycle, no pop, output stays empty.
REQ-037 5 lines preloaded, ctx_length=3 -> 3 results, input_fifo_count=2 at DONE; second start with ctx_length=2 consumes the rest.
REQ-038 reset asserted with 4 lines in flight -> all outputs at reset values, no stale output write after reset.
